// File: rtl/tour_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd_seq_pkg
//  Purpose  : Shared types and constants for the knight's-tour command
//             sequencer. Holds the FSM state type, the opcode, heading and
//             fault codes, and the one-hot move to (dx, dy) table.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tour_cmd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XSTART = 3'd1,
    S_XWAIT  = 3'd2,
    S_YSTART = 3'd3,
    S_YWAIT  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

  // Leg lengths kept as 3-bit two's complement (range -2..+2).
  typedef struct packed {
    logic [2:0] dx;
    logic [2:0] dy;
  } delta_t;

  // Non-one-hot moves return a zero delta; the caller flags them separately.
  function automatic delta_t move_delta(input logic [7:0] move);
    delta_t d;
    d = '0;
    case (move)
      8'h01:   begin d.dx = 3'b111; d.dy = 3'b010; end
      8'h02:   begin d.dx = 3'b001; d.dy = 3'b010; end
      8'h04:   begin d.dx = 3'b110; d.dy = 3'b001; end
      8'h08:   begin d.dx = 3'b110; d.dy = 3'b111; end
      8'h10:   begin d.dx = 3'b111; d.dy = 3'b110; end
      8'h20:   begin d.dx = 3'b001; d.dy = 3'b110; end
      8'h40:   begin d.dx = 3'b010; d.dy = 3'b111; end
      8'h80:   begin d.dx = 3'b010; d.dy = 3'b001; end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Magnitude of a 3-bit two's complement leg, widened to the squares field.
  function automatic logic [3:0] leg_squares(input logic [2:0] v);
    logic [2:0] neg;
    neg = ~v + 3'd1;
    return v[2] ? {1'b0, neg} : {1'b0, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tour_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd_seq_if
//  Purpose  : Bundles the sequencer's control, UART pass-through, command
//             processor handshake and status signals.
//  Ports    : master - drives start_tour/abort/move/cmd_UART/cmd_rdy_UART/
//                      clr_cmd_rdy/send_resp, observes the outputs
//             slave  - the sequencer side (mirror of master)
//  Revision : 1.0  initial release
// ============================================================================
interface tour_cmd_seq_if #(
  parameter int NUM_MOVES = 24
) ();
  localparam int IDX_W = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;

  logic             start_tour;
  logic             abort;
  logic [7:0]       move;
  logic [15:0]      cmd_UART;
  logic             cmd_rdy_UART;
  logic             clr_cmd_rdy;
  logic             send_resp;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_rdy;
  logic [7:0]       resp;
  logic             tour_done;
  logic [1:0]       tour_fault;

  modport master (
    output start_tour, abort, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, cmd, cmd_rdy, resp, tour_done, tour_fault
  );

  modport slave (
    input  start_tour, abort, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, cmd, cmd_rdy, resp, tour_done, tour_fault
  );
endinterface
`default_nettype wire

// File: rtl/tour_cmd_seq_move_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd_seq_move_decode
//  Purpose  : Turns a one-hot knight move plus the active leg into the 16-bit
//             motion command {op, heading, squares}; flags non-one-hot moves.
//  Ports    : i_move    in  8   one-hot move
//             i_leg_y   in  1   0 = X leg, 1 = Y leg
//             i_fanfare in  1   Y leg uses the fanfare opcode
//             o_cmd     out 16  motion command
//             o_illegal out 1   move is not one-hot
//  Revision : 1.0  initial release
// ============================================================================
module tour_cmd_seq_move_decode
  import tour_cmd_seq_pkg::*;
(
  input  logic [7:0]  i_move,
  input  logic        i_leg_y,
  input  logic        i_fanfare,
  output logic [15:0] o_cmd,
  output logic        o_illegal
);

  delta_t     w_d;
  logic [3:0] w_op;
  logic [7:0] w_hdg;
  logic [3:0] w_sq;

  always_comb begin
    w_d       = move_delta(i_move);
    o_illegal = (i_move == 8'h00) || ((i_move & (i_move - 8'd1)) != 8'h00);
    if (i_leg_y) begin
      w_op  = i_fanfare ? OP_FANFARE : OP_MOVE;
      w_hdg = (!w_d.dy[2] && (w_d.dy != 3'd0)) ? HDG_N : HDG_S;
      w_sq  = leg_squares(w_d.dy);
    end else begin
      w_op  = OP_MOVE;
      w_hdg = w_d.dx[2] ? HDG_W : HDG_E;
      w_sq  = leg_squares(w_d.dx);
    end
    o_cmd = {w_op, w_hdg, w_sq};
  end

endmodule
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd_seq
//  Purpose  : Replays a solved knight's tour as X-leg then Y-leg commands to
//             the command processor; passes UART commands through while not
//             touring. Supports abort, response timeout and fault reporting.
//  Ports    : clk    in  1  system clock
//             rst_n  in  1  synchronous active-low reset
//             bus    slave modport of tour_cmd_seq_if (control, UART path,
//                    handshake, mv_indx/cmd/cmd_rdy/resp/tour_done/tour_fault)
//  Revision : 1.0  initial release
// ============================================================================
module tour_cmd_seq
  import tour_cmd_seq_pkg::*;
#(
  parameter int         NUM_MOVES    = 24,
  parameter int         FANFARE_MODE = 1,
  parameter int         TIMEOUT_CYC  = 1_000_000,
  parameter logic [7:0] RESP_DONE    = 8'hA5,
  parameter logic [7:0] RESP_ACK     = 8'h5A
) (
  input  logic           clk,
  input  logic           rst_n,
  tour_cmd_seq_if.slave  bus
);

  localparam int IDX_W = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit               C_TO_EN    = (TIMEOUT_CYC != 0);

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic [CNT_W-1:0] r_to_cnt;
  logic [1:0]       r_tour_fault;
  logic             r_tour_done;

  logic        w_last;
  logic        w_timeout;
  logic        w_leg_y;
  logic        w_fanfare;
  logic [15:0] w_dec_cmd;
  logic        w_illegal;
  logic [15:0] w_cmd;
  logic        w_cmd_rdy;

  assign w_last  = (r_mv_indx == C_LAST_IDX);
  // The counter holds the number of WAIT cycles already spent; the cycle in
  // which it reads TIMEOUT_CYC-1 is the last one in which send_resp may land.
  assign w_timeout = C_TO_EN && (r_to_cnt == C_TO_LAST);
  assign w_leg_y   = (r_state == S_YSTART) || (r_state == S_YWAIT);

  if (FANFARE_MODE == 1) begin : g_fan_every
    assign w_fanfare = 1'b1;
  end else if (FANFARE_MODE == 2) begin : g_fan_last
    assign w_fanfare = w_last;
  end else begin : g_fan_never
    assign w_fanfare = 1'b0;
  end

  tour_cmd_seq_move_decode u_decode (
    .i_move    (bus.move),
    .i_leg_y   (w_leg_y),
    .i_fanfare (w_fanfare),
    .o_cmd     (w_dec_cmd),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mv_indx    <= '0;
      r_to_cnt     <= '0;
      r_tour_fault <= FAULT_NONE;
      r_tour_done  <= 1'b0;
    end else begin
      r_tour_done <= 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_FAULT: begin
            if (bus.start_tour) begin
              r_mv_indx    <= '0;
              r_tour_fault <= FAULT_NONE;
              r_state      <= S_XSTART;
            end
          end
          S_XSTART: begin
            if (w_illegal) begin
              r_tour_fault <= FAULT_ILLEGAL;
              r_state      <= S_FAULT;
            end else if (bus.clr_cmd_rdy) begin
              r_to_cnt <= '0;
              r_state  <= S_XWAIT;
            end
          end
          S_XWAIT: begin
            if (bus.send_resp) begin
              r_state <= S_YSTART;
            end else if (w_timeout) begin
              r_tour_fault <= FAULT_TIMEOUT;
              r_state      <= S_FAULT;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_YSTART: begin
            if (bus.clr_cmd_rdy) begin
              r_to_cnt <= '0;
              r_state  <= S_YWAIT;
            end
          end
          S_YWAIT: begin
            if (bus.send_resp) begin
              if (w_last) begin
                r_tour_done <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_mv_indx <= r_mv_indx + 1'b1;
                r_state   <= S_XSTART;
              end
            end else if (w_timeout) begin
              r_tour_fault <= FAULT_TIMEOUT;
              r_state      <= S_FAULT;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Command path: UART pass-through when not touring, decoded leg otherwise.
  always_comb begin
    w_cmd     = w_dec_cmd;
    w_cmd_rdy = 1'b0;
    case (r_state)
      S_IDLE, S_FAULT: begin
        w_cmd     = bus.cmd_UART;
        w_cmd_rdy = bus.cmd_rdy_UART;
      end
      S_XSTART: w_cmd_rdy = !w_illegal;
      S_YSTART: w_cmd_rdy = 1'b1;
      default:  w_cmd_rdy = 1'b0;
    endcase
  end

  assign bus.cmd        = w_cmd;
  assign bus.cmd_rdy    = w_cmd_rdy;
  assign bus.mv_indx    = r_mv_indx;
  assign bus.resp       = w_last ? RESP_DONE : RESP_ACK;
  assign bus.tour_done  = r_tour_done;
  assign bus.tour_fault = r_tour_fault;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tour_cmd_seq
//  Purpose  : Self-checking bench for tour_cmd_seq. Two instances: A with
//             NUM_MOVES=24, FANFARE_MODE=1, TIMEOUT_CYC=16 and B with
//             NUM_MOVES=4, FANFARE_MODE=2. Expected commands come from the
//             knight move table evaluated with plain integer arithmetic.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_tour_cmd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_tour = 1'b0, abort = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic        cmd_rdy_UART = 1'b0;
  logic [7:0]  move = 8'h02;
  logic [15:0] cmd_UART = 16'h0000;
  bit          sel_b = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  int dxt[8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
  int dyt[8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

  tour_cmd_seq_if #(.NUM_MOVES(24)) ifa ();
  tour_cmd_seq_if #(.NUM_MOVES(4))  ifb ();

  assign ifa.start_tour = start_tour && !sel_b;
  assign ifb.start_tour = start_tour && sel_b;
  assign ifa.abort = abort;               assign ifb.abort = abort;
  assign ifa.move = move;                 assign ifb.move = move;
  assign ifa.cmd_UART = cmd_UART;         assign ifb.cmd_UART = cmd_UART;
  assign ifa.cmd_rdy_UART = cmd_rdy_UART; assign ifb.cmd_rdy_UART = cmd_rdy_UART;
  assign ifa.clr_cmd_rdy = clr_cmd_rdy;   assign ifb.clr_cmd_rdy = clr_cmd_rdy;
  assign ifa.send_resp = send_resp;       assign ifb.send_resp = send_resp;

  tour_cmd_seq #(.NUM_MOVES(24), .FANFARE_MODE(1), .TIMEOUT_CYC(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  tour_cmd_seq #(.NUM_MOVES(4), .FANFARE_MODE(2), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [15:0] w_cmd;
  logic        w_cmd_rdy, w_done;
  logic [7:0]  w_resp;
  logic [1:0]  w_fault;
  int          w_mv;
  assign w_cmd     = sel_b ? ifb.cmd : ifa.cmd;
  assign w_cmd_rdy = sel_b ? ifb.cmd_rdy : ifa.cmd_rdy;
  assign w_done    = sel_b ? ifb.tour_done : ifa.tour_done;
  assign w_resp    = sel_b ? ifb.resp : ifa.resp;
  assign w_fault   = sel_b ? ifb.tour_fault : ifa.tour_fault;
  assign w_mv      = sel_b ? int'(ifb.mv_indx) : int'(ifa.mv_indx);

  always @(negedge clk) if (w_done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // Expected command for move bit b on the given leg.
  function automatic logic [15:0] ref_cmd(input int b, input bit y, input bit fan);
    int d, mag;
    logic [3:0] op;
    logic [7:0] h;
    d   = y ? dyt[b] : dxt[b];
    mag = (d < 0) ? -d : d;
    op  = (y && fan) ? 4'h3 : 4'h2;
    if (y) h = (d > 0) ? 8'h00 : 8'h7F;
    else   h = (d < 0) ? 8'h3F : 8'hBF;
    return {op, h, mag[3:0]};
  endfunction

  function automatic int pick(input int fixed_bit);
    return (fixed_bit >= 0) ? fixed_bit : int'($urandom_range(7));
  endfunction

  // Entered at a negedge in (or just before) a START state; leaves the DUT in WAIT.
  task automatic do_leg(input logic [15:0] exp_cmd, input int exp_idx, input int num,
                        input int dly, input string nm);
    int w = 0;
    while (w_cmd_rdy !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    n_tests++; if (w_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL %s_rdy idx %0d: cmd_rdy=%b required 1", nm, exp_idx, w_cmd_rdy); end
    n_tests++; if (w_cmd !== exp_cmd) begin n_fail++; $display("FAIL %s_cmd idx %0d: cmd=%h required %h", nm, exp_idx, w_cmd, exp_cmd); end
    n_tests++; if (w_mv !== exp_idx) begin n_fail++; $display("FAIL %s_idx: mv_indx=%0d required %0d", nm, w_mv, exp_idx); end
    n_tests++; if (w_resp !== ((exp_idx == num - 1) ? 8'hA5 : 8'h5A)) begin n_fail++; $display("FAIL %s_resp idx %0d: resp=%h", nm, exp_idx, w_resp); end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL %s_wait_rdy idx %0d: cmd_rdy=%b required 0", nm, exp_idx, w_cmd_rdy); end
    repeat (dly) @(negedge clk);
  endtask

  // Runs a tour; stop_at >= 0 returns in the YWAIT of that move without responding.
  task automatic run_tour(input int num, input int fixed_bit, input bit rnd_dly, input int stop_at);
    int b, nb, d0;
    bit fan;
    d0 = done_cnt;
    b = pick(fixed_bit);
    move = 8'(1 << b);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    for (int i = 0; i < num; i++) begin
      fan = sel_b ? (i == num - 1) : 1'b1;
      do_leg(ref_cmd(b, 1'b0, 1'b0), i, num, rnd_dly ? int'($urandom_range(5)) : 0, "xleg");
      send_resp = 1'b1; @(negedge clk); send_resp = 1'b0;
      do_leg(ref_cmd(b, 1'b1, fan), i, num, rnd_dly ? int'($urandom_range(5)) : 0, "yleg");
      if (i == stop_at) return;
      nb = pick(fixed_bit);
      send_resp = 1'b1; move = 8'(1 << nb);
      @(negedge clk);
      send_resp = 1'b0;
      b = nb;
    end
    n_tests++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: tour_done=%b required 1", w_done); end
    n_tests++; if (w_mv !== num - 1) begin n_fail++; $display("FAIL final_idx: mv_indx=%0d required %0d", w_mv, num - 1); end
    n_tests++; if (w_resp !== 8'hA5) begin n_fail++; $display("FAIL final_resp: resp=%h required a5", w_resp); end
    @(negedge clk);
    n_tests++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL done_once: tour_done=%b required 0", w_done); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL done_count: pulses=%0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (w_mv !== 0) begin n_fail++; $display("FAIL reset_idx: mv_indx=%0d required 0", w_mv); end
    n_tests++; if (w_fault !== 2'b00) begin n_fail++; $display("FAIL reset_fault: tour_fault=%b required 00", w_fault); end
    n_tests++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: tour_done=%b required 0", w_done); end
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: cmd_rdy=%b required 0", w_cmd_rdy); end
    n_tests++; if (w_resp !== 8'h5A) begin n_fail++; $display("FAIL reset_resp: resp=%h required 5a", w_resp); end
  endtask

  task automatic test_idle_passthru;
    for (int k = 0; k < 4; k++) begin
      cmd_UART = 16'($urandom);
      cmd_rdy_UART = 1'($urandom_range(1));
      @(negedge clk);
      n_tests++; if (w_cmd !== cmd_UART) begin n_fail++; $display("FAIL idle_cmd: cmd=%h required %h", w_cmd, cmd_UART); end
      n_tests++; if (w_cmd_rdy !== cmd_rdy_UART) begin n_fail++; $display("FAIL idle_rdy: cmd_rdy=%b required %b", w_cmd_rdy, cmd_rdy_UART); end
    end
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; move = 8'h02; start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    n_tests++; if (w_cmd !== 16'h2BF1) begin n_fail++; $display("FAIL tour_cmd_not_uart: cmd=%h required 2bf1", w_cmd); end
    clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0;
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL wait_ignores_uart: cmd_rdy=%b required 0", w_cmd_rdy); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_tests++; if (w_cmd !== 16'h1234 || w_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_after_abort: cmd=%h rdy=%b required 1234/1", w_cmd, w_cmd_rdy); end
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_abort_with_resp;
    int d0;
    d0 = done_cnt;
    run_tour(24, -1, 1'b1, 5);
    abort = 1'b1; send_resp = 1'b1; cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1;
    @(negedge clk);
    abort = 1'b0; send_resp = 1'b0;
    n_tests++; if (w_mv !== 5) begin n_fail++; $display("FAIL abort_idx: mv_indx=%0d required 5", w_mv); end
    n_tests++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: tour_done=%b required 0", w_done); end
    n_tests++; if (w_cmd_rdy !== 1'b1 || w_cmd !== cmd_UART) begin n_fail++; $display("FAIL abort_idle: cmd=%h rdy=%b required %h/1", w_cmd, w_cmd_rdy, cmd_UART); end
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_no_done: pulses=%0d required 0", done_cnt - d0); end
  endtask

  task automatic test_illegal_move;
    logic [7:0] bad;
    int b;
    do bad = 8'($urandom_range(255)); while ($countones(bad) == 1);
    move = bad; start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    n_tests++; if (w_mv !== 0) begin n_fail++; $display("FAIL start_clears_idx: mv_indx=%0d required 0", w_mv); end
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_rdy: move=%h cmd_rdy=%b required 0", bad, w_cmd_rdy); end
    @(negedge clk);
    n_tests++; if (w_fault !== 2'b10) begin n_fail++; $display("FAIL illegal_fault: tour_fault=%b required 10", w_fault); end
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL fault_rdy: cmd_rdy=%b required 0", w_cmd_rdy); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_tests++; if (w_fault !== 2'b10) begin n_fail++; $display("FAIL abort_keeps_fault: tour_fault=%b required 10", w_fault); end
    b = pick(-1); move = 8'(1 << b); start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    n_tests++; if (w_fault !== 2'b00) begin n_fail++; $display("FAIL restart_fault: tour_fault=%b required 00", w_fault); end
    n_tests++; if (w_cmd_rdy !== 1'b1 || w_cmd !== ref_cmd(b, 1'b0, 1'b0)) begin n_fail++; $display("FAIL restart_cmd: cmd=%h rdy=%b required %h/1", w_cmd, w_cmd_rdy, ref_cmd(b, 1'b0, 1'b0)); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_timeout;
    int b;
    b = pick(-1); move = 8'(1 << b); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0;
    clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      n_tests++; if (w_fault !== 2'b00) begin n_fail++; $display("FAIL to_early cycle %0d: tour_fault=%b required 00", k, w_fault); end
      if (k == 16) begin cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1; end
      @(negedge clk);
    end
    n_tests++; if (w_fault !== 2'b01) begin n_fail++; $display("FAIL to_fault: tour_fault=%b required 01", w_fault); end
    n_tests++; if (w_cmd_rdy !== 1'b1 || w_cmd !== cmd_UART) begin n_fail++; $display("FAIL to_passthru: cmd=%h rdy=%b required %h/1", w_cmd, w_cmd_rdy, cmd_UART); end
    cmd_rdy_UART = 1'b0;
    b = pick(-1); move = 8'(1 << b); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0;
    clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0;
    repeat (15) @(negedge clk);
    send_resp = 1'b1; @(negedge clk); send_resp = 1'b0;
    n_tests++; if (w_fault !== 2'b00) begin n_fail++; $display("FAIL to_last_cycle_fault: tour_fault=%b required 00", w_fault); end
    n_tests++; if (w_cmd_rdy !== 1'b1 || w_cmd !== ref_cmd(b, 1'b1, 1'b1)) begin n_fail++; $display("FAIL to_last_cycle_y: cmd=%h rdy=%b required %h/1", w_cmd, w_cmd_rdy, ref_cmd(b, 1'b1, 1'b1)); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_fanfare_last_and_reset;
    sel_b = 1'b1;
    run_tour(4, 7, 1'b0, -1);
    run_tour(4, 7, 1'b0, 1);
    send_resp = 1'b1; @(negedge clk); send_resp = 1'b0;
    do_leg(16'h2BF2, 2, 4, 0, "b_xleg");
    send_resp = 1'b1; @(negedge clk); send_resp = 1'b0;
    n_tests++; if (w_cmd_rdy !== 1'b1 || w_cmd !== 16'h2001) begin n_fail++; $display("FAIL b_ystart: cmd=%h rdy=%b required 2001/1", w_cmd, w_cmd_rdy); end
    rst_n = 1'b0; @(negedge clk);
    n_tests++; if (w_mv !== 0) begin n_fail++; $display("FAIL mid_reset_idx: mv_indx=%0d required 0", w_mv); end
    n_tests++; if (w_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rdy: cmd_rdy=%b required 0", w_cmd_rdy); end
    rst_n = 1'b1; @(negedge clk);
    n_tests++; if (w_cmd_rdy !== 1'b0 || w_mv !== 0) begin n_fail++; $display("FAIL post_reset_idle: rdy=%b idx=%0d required 0/0", w_cmd_rdy, w_mv); end
    sel_b = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_passthru();
    run_tour(24, 1, 1'b0, -1);
    run_tour(24, -1, 1'b1, -1);
    run_tour(24, -1, 1'b1, -1);
    test_abort_with_resp();
    test_illegal_move();
    test_timeout();
    test_fanfare_last_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
